// File: rtl/mmu_timer_arb.sv
// mmu_timer_arb
//   Two-master arbiter and sequencer for the interval timer's single register
//   port. M0 (CPU) and M1 (DMA/debug loader) share the en/addr/rw/din/dout bus
//   with round-robin grant, one bus access per grant, and a req/done
//   handshake. Also turns the timer's level zero-count signal into a sticky
//   pending flag with an ack handshake.
//
//   Build option: define TMR_ARB_MISSCNT_EN to get a saturating count of
//   interrupts lost while pending on int_miss. Without it int_miss is 4'h0.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   mX_req/rw/addr/wdata master X request (held until mX_done), 1=read
//   mX_done              one-cycle pulse, access finished, mX_rdata valid
//   mX_rdata             registered read data, holds between reads
//   tmr_en/rw/addr/din   timer bus, driven only in the access cycle
//   tmr_dout             combinational read data from timer
//   tmr_int              timer zero-count level
//   int_pend, int_ack    sticky pending flag and its clear
//   int_miss             lost-interrupt count (optional)
module mmu_timer_arb #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 2,
    parameter int RST_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              tmr_en,
    output logic              tmr_rw,
    output logic [ADDR_W-1:0] tmr_addr,
    output logic [DATA_W-1:0] tmr_din,
    input  logic [DATA_W-1:0] tmr_dout,
    input  logic              tmr_int,
    output logic              int_pend,
    input  logic              int_ack,
    output logic [3:0]        int_miss
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_nx;
    logic                win;        // 0 = M0 owns the current access, 1 = M1
    logic                rr_ptr;     // master favoured on a tie
    logic                lat_rw;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [1:0][DATA_W-1:0] rdata_q;
    logic                tmr_int_q;
    logic                pick_m1;
    logic                start;
    logic                rise;

    // M1 wins if it is alone, or on a tie when the pointer favours it.
    assign pick_m1 = m1_req & (~m0_req | rr_ptr);
    assign start   = (state == IDLE) & (m0_req | m1_req);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (m0_req | m1_req) state_nx = ACC;
            ACC:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tmr_en   = 1'b0;
        tmr_rw   = 1'b0;
        tmr_addr = '0;
        tmr_din  = '0;
        m0_done  = 1'b0;
        m1_done  = 1'b0;
        case (state)
            ACC: begin
                tmr_en   = 1'b1;
                tmr_rw   = lat_rw;
                tmr_addr = lat_addr;
                tmr_din  = lat_wdata;
            end
            DONE: begin
                m0_done = ~win;
                m1_done = win;
            end
            default: ;
        endcase
    end

    // Grant: latch the winner's request; the pointer always moves to the
    // loser (or to the idle master on a single request), i.e. ~winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= 1'b0;
            rr_ptr    <= 1'(RST_PRI);
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (start) begin
            win       <= pick_m1;
            rr_ptr    <= ~pick_m1;
            lat_rw    <= pick_m1 ? m1_rw    : m0_rw;
            lat_addr  <= pick_m1 ? m1_addr  : m0_addr;
            lat_wdata <= pick_m1 ? m1_wdata : m0_wdata;
        end
    end

    // Read data is captured at the end of ACC into the winner's slot only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state == ACC && lat_rw) begin
            for (int i = 0; i < 2; i++)
                if (win == 1'(i)) rdata_q[i] <= tmr_dout;
        end
    end

    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];

    // ---------------- interrupt latch ----------------
    // Edge detect so a timer stuck at zero reload raises only one event.
    assign rise = tmr_int & ~tmr_int_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_int_q <= 1'b0;
            int_pend  <= 1'b0;
        end else begin
            tmr_int_q <= tmr_int;
            if (rise)         int_pend <= 1'b1;   // a new event beats ack
            else if (int_ack) int_pend <= 1'b0;
        end
    end

`ifdef TMR_ARB_MISSCNT_EN
    logic [3:0] miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_q <= 4'h0;
        end else if (rise) begin
            if (int_pend && !int_ack && miss_q != 4'hF) miss_q <= miss_q + 4'h1;
        end else if (int_ack) begin
            miss_q <= 4'h0;
        end
    end

    assign int_miss = miss_q;
`else
    assign int_miss = 4'h0;
`endif

endmodule

// File: tb/tb_mmu_timer_arb.sv
module tb_mmu_timer_arb;

    localparam int DW = 24;
    localparam int AW = 2;
`ifdef TMR_ARB_MISSCNT_EN
    localparam bit MISS_ON = 1'b1;
`else
    localparam bit MISS_ON = 1'b0;
`endif
    localparam logic [DW-1:0] JUNK = 24'hDEAD00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 0, m0_rw = 0, m1_req = 0, m1_rw = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_done, m1_done;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          tmr_en, tmr_rw;
    logic [AW-1:0] tmr_addr;
    logic [DW-1:0] tmr_din;
    logic [DW-1:0] tmr_dout = JUNK;
    logic          tmr_int = 0, int_ack = 0;
    logic          int_pend;
    logic [3:0]    int_miss;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmu_timer_arb #(.DATA_W(DW), .ADDR_W(AW), .RST_PRI(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata),
        .tmr_en(tmr_en), .tmr_rw(tmr_rw), .tmr_addr(tmr_addr), .tmr_din(tmr_din),
        .tmr_dout(tmr_dout), .tmr_int(tmr_int),
        .int_pend(int_pend), .int_ack(int_ack), .int_miss(int_miss)
    );

    typedef struct {
        logic          m;       // 0 = M0, 1 = M1
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] dout;    // timer read data presented during ACC
        logic [DW-1:0] exp_r0;
        logic [DW-1:0] exp_r1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single-master access: req at negedge, ACC next cycle, DONE the one after.
    task automatic do_xact(input vec_t v, input string tag);
        @(negedge clk);
        m0_req = ~v.m; m1_req = v.m;
        m0_rw = v.rw; m1_rw = v.rw;
        m0_addr = v.addr; m1_addr = v.addr;
        m0_wdata = v.m ? 24'h0 : v.wdata;
        m1_wdata = v.m ? v.wdata : 24'h0;
        tmr_dout = JUNK;
        @(negedge clk);
        chk({tag, " acc en"},   32'(tmr_en),   32'd1);
        chk({tag, " acc rw"},   32'(tmr_rw),   32'(v.rw));
        chk({tag, " acc addr"}, 32'(tmr_addr), 32'(v.addr));
        chk({tag, " acc din"},  32'(tmr_din),  32'(v.wdata));
        chk({tag, " acc done"}, 32'({m1_done, m0_done}), 32'd0);
        tmr_dout = v.dout;
        @(negedge clk);
        tmr_dout = JUNK;
        chk({tag, " done"},    32'({m1_done, m0_done}), v.m ? 32'd2 : 32'd1);
        chk({tag, " done en"}, 32'(tmr_en),   32'd0);
        chk({tag, " r0"},      32'(m0_rdata), 32'(v.exp_r0));
        chk({tag, " r1"},      32'(m1_rdata), 32'(v.exp_r1));
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        chk({tag, " idle"}, 32'({tmr_en, m1_done, m0_done}), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd0, 24'h000010, 24'h5A5A5A, 24'h000000, 24'h000000};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 24'h000000, 24'h00ABCD, 24'h000000, 24'h00ABCD};
        vecs[2] = '{1'b0, 1'b1, 2'd2, 24'h000000, 24'h123456, 24'h123456, 24'h00ABCD};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 24'hFFFFFF, 24'h777777, 24'h123456, 24'h00ABCD};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 24'h000000, 24'h654321, 24'h123456, 24'h00ABCD};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 24'h000000, 24'h000001, 24'h123456, 24'h000001};

        // reset state
        @(negedge clk);
        chk("rst bus",  32'({tmr_en, tmr_rw, tmr_addr}), 32'd0);
        chk("rst din",  32'(tmr_din), 32'd0);
        chk("rst done", 32'({m1_done, m0_done}), 32'd0);
        chk("rst rd",   32'(m0_rdata | m1_rdata), 32'd0);
        chk("rst int",  32'({int_pend, int_miss}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // table of single-master accesses
        for (int i = 0; i < 6; i++) do_xact(vecs[i], $sformatf("vec%0d", i));

        // both masters held from reset: M0, M1, M0, one access per 3 cycles
        do_reset();
        @(negedge clk);
        m0_req = 1; m0_rw = 0; m0_addr = 2'd1; m0_wdata = 24'h000111;
        m1_req = 1; m1_rw = 0; m1_addr = 2'd2; m1_wdata = 24'h000222;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("rr c%0d en", c), 32'(tmr_en), (c % 3 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rr c%0d din", c), 32'(tmr_din),
                (c == 4) ? 32'h222 : ((c % 3 == 1) ? 32'h111 : 32'h0));
            chk($sformatf("rr c%0d done", c), 32'({m1_done, m0_done}),
                (c == 2 || c == 8) ? 32'd1 : ((c == 5) ? 32'd2 : 32'd0));
            if (c == 9) begin m0_req = 0; m1_req = 0; end
        end
        @(negedge clk);
        chk("rr quiet", 32'({tmr_en, m1_done, m0_done}), 32'd0);

        // reset during ACC aborts the access with no done pulse
        m0_req = 1; m0_rw = 0; m0_addr = 2'd3; m0_wdata = 24'h000033;
        @(negedge clk);
        chk("abort acc en", 32'(tmr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort en", 32'({tmr_en, tmr_din}), 32'd0);
        chk("abort done", 32'({m1_done, m0_done}), 32'd0);
        m0_req = 0;
        @(negedge clk);
        chk("abort no done", 32'({tmr_en, m1_done, m0_done}), 32'd0);
        rst = 1'b0;
        begin
            vec_t v;
            v = '{1'b0, 1'b1, 2'd3, 24'h000000, 24'h00BEEF, 24'h00BEEF, 24'h000000};
            do_xact(v, "post-abort");
        end

        // interrupt: single pulse, then re-rise and hold high
        @(negedge clk); tmr_int = 1;
        @(negedge clk); chk("int rise1 pend", 32'(int_pend), 32'd1);
        chk("int rise1 miss", 32'(int_miss), 32'd0);
        tmr_int = 0;
        @(negedge clk); chk("int low pend", 32'(int_pend), 32'd1);
        tmr_int = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("int hold%0d pend", c), 32'(int_pend), 32'd1);
            chk($sformatf("int hold%0d miss", c), 32'(int_miss), MISS_ON ? 32'd1 : 32'd0);
        end
        // rise coincident with ack: pending stays, count unchanged
        tmr_int = 0;
        @(negedge clk); tmr_int = 1; int_ack = 1;
        @(negedge clk);
        chk("rise+ack pend", 32'(int_pend), 32'd1);
        chk("rise+ack miss", 32'(int_miss), MISS_ON ? 32'd1 : 32'd0);
        // ack with the level still high (no rise) clears
        @(negedge clk);
        chk("ack pend", 32'(int_pend), 32'd0);
        chk("ack miss", 32'(int_miss), 32'd0);
        int_ack = 0; tmr_int = 0;
        // 20 rises without ack saturate the miss count
        for (int r = 0; r < 20; r++) begin
            @(negedge clk); tmr_int = 1;
            @(negedge clk); tmr_int = 0;
        end
        @(negedge clk);
        chk("sat pend", 32'(int_pend), 32'd1);
        chk("sat miss", 32'(int_miss), MISS_ON ? 32'hF : 32'd0);
        int_ack = 1;
        @(negedge clk);
        int_ack = 0;
        chk("sat clr", 32'({int_pend, int_miss}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
